// File: rtl/div_share_ctrl.sv
// div_share_ctrl: arbitrates NREQ requesters onto one shared combinational divider.
// Define ARB_RR_EN for round-robin arbitration; the default build uses fixed lowest-index priority.
module div_share_ctrl #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDXW  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_in1,
  input  logic [NREQ*WIDTH-1:0] req_in2,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [WIDTH-1:0]      resp_quot,
  output logic                  resp_dbz,
  output logic [WIDTH-1:0]      div_a,
  output logic [WIDTH-1:0]      div_b,
  input  logic [WIDTH-1:0]      div_q,
  output logic                  busy,
  output logic [IDXW-1:0]       owner
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] div_a_q, div_a_d;
  logic [WIDTH-1:0] div_b_q, div_b_d;
  logic [WIDTH-1:0] res_quot_q, res_quot_d;
  logic            res_dbz_q, res_dbz_d;
  logic [IDXW-1:0] owner_q, owner_d;

  logic            grant_vld;
  logic [IDXW-1:0] grant_idx;
  logic            owner_ready;

  logic [WIDTH-1:0] in1_arr [NREQ];
  logic [WIDTH-1:0] in2_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign in1_arr[gi] = req_in1[gi*WIDTH +: WIDTH];
      assign in2_arr[gi] = req_in2[gi*WIDTH +: WIDTH];
    end
  endgenerate

`ifdef ARB_RR_EN
  logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
  logic            hi_vld;
  logic [IDXW-1:0] hi_idx, lo_idx;

  // Prefer the lowest valid index at or above rr_ptr; otherwise wrap to the lowest valid index.
  always_comb begin
    hi_vld    = 1'b0;
    hi_idx    = '0;
    lo_idx    = '0;
    grant_vld = 1'b0;
    for (int j = NREQ-1; j >= 0; j--) begin
      if (req_valid[j]) begin
        grant_vld = 1'b1;
        lo_idx    = IDXW'(j);
        if (j >= int'(rr_ptr_q)) begin
          hi_vld = 1'b1;
          hi_idx = IDXW'(j);
        end
      end
    end
    grant_idx = hi_vld ? hi_idx : lo_idx;
  end
`else
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int j = NREQ-1; j >= 0; j--) begin
      if (req_valid[j]) begin
        grant_vld = 1'b1;
        grant_idx = IDXW'(j);
      end
    end
  end
`endif

  always_comb begin
    owner_ready = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (IDXW'(j) == owner_q) owner_ready = resp_ready[j];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      div_a_q    <= '0;
      div_b_q    <= '0;
      res_quot_q <= '0;
      res_dbz_q  <= 1'b0;
      owner_q    <= '0;
`ifdef ARB_RR_EN
      rr_ptr_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      div_a_q    <= div_a_d;
      div_b_q    <= div_b_d;
      res_quot_q <= res_quot_d;
      res_dbz_q  <= res_dbz_d;
      owner_q    <= owner_d;
`ifdef ARB_RR_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    div_a_d    = div_a_q;
    div_b_d    = div_b_q;
    res_quot_d = res_quot_q;
    res_dbz_d  = res_dbz_q;
    owner_d    = owner_q;
`ifdef ARB_RR_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          for (int j = 0; j < NREQ; j++) begin
            if (IDXW'(j) == grant_idx) begin
              div_a_d = in1_arr[j];
              div_b_d = in2_arr[j];
            end
          end
          owner_d = grant_idx;
`ifdef ARB_RR_EN
          rr_ptr_d = (int'(grant_idx) == NREQ-1) ? '0 : IDXW'(grant_idx + 1'b1);
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        // Zero divisor is detected locally; the divider's own output is don't-care then.
        res_dbz_d  = (div_b_q == '0);
        res_quot_d = res_dbz_d ? '1 : div_q;
        state_d    = RESP;
      end
      RESP: begin
        if (owner_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    busy       = (state_q != IDLE);
    for (int j = 0; j < NREQ; j++) begin
      if (rst_n && state_q == IDLE && grant_vld && IDXW'(j) == grant_idx) req_ready[j] = 1'b1;
      if (state_q == RESP && IDXW'(j) == owner_q) resp_valid[j] = 1'b1;
    end
  end

  assign div_a     = div_a_q;
  assign div_b     = div_b_q;
  assign resp_quot = res_quot_q;
  assign resp_dbz  = res_dbz_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// Scoreboard bench for div_share_ctrl: a transaction-level model predicts grants and results,
// a separate monitor pops expected responses as the DUT presents them.
module tb_div_share_ctrl;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int IDXW  = 2;

  logic                  clk   = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_in1 = '0;
  logic [NREQ*WIDTH-1:0] req_in2 = '0;
  logic [NREQ-1:0]       resp_valid;
  logic [NREQ-1:0]       resp_ready = '1;
  logic [WIDTH-1:0]      resp_quot;
  logic                  resp_dbz;
  logic [WIDTH-1:0]      div_a, div_b, div_q;
  logic                  busy;
  logic [IDXW-1:0]       owner;

  div_share_ctrl #(.WIDTH(WIDTH), .NREQ(NREQ), .IDXW(IDXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_quot(resp_quot), .resp_dbz(resp_dbz),
    .div_a(div_a), .div_b(div_b), .div_q(div_q),
    .busy(busy), .owner(owner)
  );

  // Stand-in divider; returns junk on zero divisor so the controller must override it.
  assign div_q = (div_b == '0) ? 8'h5A : WIDTH'(div_a / div_b);

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int idx;
    int quot;
    int dbz;
    int acc;
  } exp_t;
  exp_t exp_q[$];

  logic m_busy       = 1'b0;
  int   m_owner      = 0;
  int   m_rr         = 0;
  logic rst_prev_low = 1'b0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Arbitration reference: first valid requester searching upward from start, with wrap.
  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    int r;
    int start;
    r = -1;
    start = ptr;
`ifndef ARB_RR_EN
    start = 0;
`endif
    for (int i = NREQ-1; i >= 0; i--) begin
      if (v[(start + i) % NREQ]) r = (start + i) % NREQ;
    end
    return r;
  endfunction

  // Model: predicts req_ready/busy/owner and pushes expected responses on acceptance.
  initial forever begin
    int p;
    int a;
    int b;
    logic [NREQ-1:0] exp_rdy;
    exp_t e;
    @(negedge clk);
    if (rst_n !== 1'b1) begin
      check("rst_req_ready", 32'(req_ready), 0);
      if (rst_prev_low) begin
        check("rst_resp_valid", 32'(resp_valid), 0);
        check("rst_busy", 32'(busy), 0);
      end
      m_busy = 1'b0;
      m_rr   = 0;
      exp_q.delete();
      rst_prev_low = 1'b1;
    end else begin
      rst_prev_low = 1'b0;
      p = pick(req_valid, m_rr);
      exp_rdy = (m_busy || p < 0) ? '0 : (NREQ'(1) << p);
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("busy", 32'(busy), 32'(m_busy));
      if (m_busy) begin
        check("owner", 32'(owner), m_owner);
        if (resp_valid[m_owner] === 1'b1 && resp_ready[m_owner]) m_busy = 1'b0;
      end else if (p >= 0) begin
        a = int'(req_in1[p*WIDTH +: WIDTH]);
        b = int'(req_in2[p*WIDTH +: WIDTH]);
        e.idx  = p;
        e.quot = (b == 0) ? (1 << WIDTH) - 1 : a / b;
        e.dbz  = (b == 0) ? 1 : 0;
        e.acc  = cyc;
        exp_q.push_back(e);
        m_busy  = 1'b1;
        m_owner = p;
`ifdef ARB_RR_EN
        m_rr = (p + 1) % NREQ;
`endif
      end
    end
  end

  // Monitor: compares the presented response against the queue head, pops on handshake.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("resp_valid_idle", 32'(resp_valid), 0);
      end else begin
        e = exp_q[0];
        if (cyc < e.acc + 2) begin
          check("resp_early", 32'(resp_valid), 0);
        end else begin
          check("resp_valid", 32'(resp_valid), 32'(1 << e.idx));
          check("resp_quot", 32'(resp_quot), e.quot);
          check("resp_dbz", 32'(resp_dbz), e.dbz);
          if (resp_valid[e.idx] === 1'b1 && resp_ready[e.idx]) begin
            void'(exp_q.pop_front());
            $display("resp req=%0d quot=%0d dbz=%0d accept_cycle=%0d done_cycle=%0d",
                     e.idx, e.quot, e.dbz, e.acc, cyc);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input int a, input int b);
    req_valid[k] = 1'b1;
    req_in1[k*WIDTH +: WIDTH] = WIDTH'(a);
    req_in2[k*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  // Returns at the sample just before the accepting edge.
  task automatic wait_accept(input int k);
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 60 && !ok; t++) begin
      @(negedge clk);
      if (rst_n && req_valid[k] && req_ready[k]) ok = 1'b1;
    end
    check("accept_timeout", 32'(ok), 1);
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 100 && (exp_q.size() != 0 || m_busy); t++) step();
    check("drain", exp_q.size(), 0);
  endtask

  task automatic do_op(input int k, input int a, input int b);
    set_req(k, a, b);
    wait_accept(k);
    step();
    req_valid[k] = 1'b0;
    wait_idle();
  endtask

  task automatic rand_op(input int k);
    int a;
    int b;
    a = $urandom_range(0, 255);
    case ($urandom_range(0, 5))
      0:       b = 0;
      1:       b = $urandom_range(1, 15);
      2:       b = a;
      default: b = $urandom_range(0, 255);
    endcase
    set_req(k, a, b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NREQ-1:0] acc;
    // Reset with every requester asserting, then contention with all four held valid.
    for (int k = 0; k < NREQ; k++) set_req(k, 10 * (k + 1) + 3, k + 1);
    resp_ready = '1;
    repeat (3) step();
    rst_n = 1'b1;
    repeat (16) step();
    req_valid = '0;
    wait_idle();

    do_op(1, 200, 7);
    do_op(2, 55, 0);
    do_op(0, 5, 9);
    do_op(3, 9, 9);
    do_op(1, 255, 1);

    // Response backpressure while requester 3 waits.
    resp_ready = '0;
    set_req(0, 77, 7);
    wait_accept(0);
    step();
    req_valid[0] = 1'b0;
    set_req(3, 100, 10);
    repeat (6) step();
    resp_ready = '1;
    wait_accept(3);
    step();
    req_valid[3] = 1'b0;
    wait_idle();

    // Reset while the divider operation is in flight; requester keeps asking.
    set_req(1, 100, 3);
    wait_accept(1);
    step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    wait_accept(1);
    step();
    req_valid[1] = 1'b0;
    wait_idle();

    // Randomized traffic, including abandoned requests and response backpressure.
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      step();
      for (int k = 0; k < NREQ; k++) begin
        if (acc[k]) req_valid[k] = 1'b0;
        else if (!req_valid[k]) begin
          if ($urandom_range(0, 2) == 0) rand_op(k);
        end else if ($urandom_range(0, 19) == 0) req_valid[k] = 1'b0;
        resp_ready[k] = ($urandom_range(0, 3) != 0);
      end
    end
    req_valid  = '0;
    resp_ready = '1;
    wait_idle();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
